// File: rtl/unsaved_sw_irq_master.sv
// unsaved_sw_irq_master: Avalon-MM master servicing a 2-bit switch PIO.
// Arms the PIO irq mask, then per irq reads/clears edge_capture, reads levels, emits an event.
//
// Ports:
//   clk, reset_n        single clock, async active-low reset
//   irq                 level interrupt from the switch PIO
//   address/chipselect/read/write_n/writedata
//                       Avalon-MM request side toward the PIO
//   readdata/waitrequest/readdatavalid
//                       Avalon-MM response side (pipelined reads)
//   event_valid/event_ready/event_edges/event_level
//                       valid/ready event output toward the consumer
//   timeout_err         sticky readdatavalid-timeout flag
module unsaved_sw_irq_master #(
  parameter logic [1:0]  MASK_INIT = 2'b11,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        irq,
  output logic [1:0]  address,
  output logic        chipselect,
  output logic        read,
  output logic        write_n,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  input  logic        readdatavalid,
  output logic        event_valid,
  input  logic        event_ready,
  output logic [1:0]  event_edges,
  output logic [1:0]  event_level,
  output logic        timeout_err
);

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MASK = 2'd2;
  localparam logic [1:0] A_EDGE = 2'd3;

  // Timeout fires on the cycle the counter would reach TIMEOUT.
  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    INIT_MASK,
    IDLE,
    RD_CAP,
    WT_CAP,
    WR_CLR,
    RD_DAT,
    WT_DAT,
    PUSH
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_armed;
  logic [7:0]  r_cnt;
  logic [1:0]  r_edges;
  logic [1:0]  r_level;
  logic        r_err;

  logic        w_cnt_clr;
  logic        w_cnt_inc;
  logic        w_cap_ld;
  logic        w_lvl_ld;
  logic        w_to;
  logic        w_unused_rd;

  assign w_unused_rd = ^readdata[31:2];

  // Next-state and datapath enables.
  always_comb begin
    w_next    = r_state;
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
    w_cap_ld  = 1'b0;
    w_lvl_ld  = 1'b0;
    w_to      = 1'b0;
    unique case (r_state)
      INIT_MASK: begin
        if (r_armed && !waitrequest) begin
          w_next = IDLE;
        end
      end
      IDLE: begin
        if (irq) begin
          w_next = RD_CAP;
        end
      end
      RD_CAP: begin
        if (!waitrequest) begin
          w_next    = WT_CAP;
          w_cnt_clr = 1'b1;
        end
      end
      WT_CAP: begin
        if (readdatavalid) begin
          w_cap_ld = 1'b1;
          // A zero capture is a spurious irq: nothing to clear.
          if (readdata[1:0] == 2'b00) begin
            w_next = IDLE;
          end else begin
            w_next = WR_CLR;
          end
        end else begin
          w_cnt_inc = 1'b1;
          if (r_cnt == LP_LAST) begin
            w_to   = 1'b1;
            w_next = IDLE;
          end
        end
      end
      WR_CLR: begin
        if (!waitrequest) begin
          w_next = RD_DAT;
        end
      end
      RD_DAT: begin
        if (!waitrequest) begin
          w_next    = WT_DAT;
          w_cnt_clr = 1'b1;
        end
      end
      WT_DAT: begin
        if (readdatavalid) begin
          w_lvl_ld = 1'b1;
          w_next   = PUSH;
        end else begin
          w_cnt_inc = 1'b1;
          if (r_cnt == LP_LAST) begin
            w_to   = 1'b1;
            w_next = IDLE;
          end
        end
      end
      PUSH: begin
        if (event_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = INIT_MASK;
      end
    endcase
  end

  // Bus outputs decode from state only.
  // r_armed keeps the mask write off the bus while reset is held.
  always_comb begin
    chipselect = 1'b0;
    read       = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'd0;
    unique case (r_state)
      INIT_MASK: begin
        if (r_armed) begin
          chipselect = 1'b1;
          write_n    = 1'b0;
          address    = A_MASK;
          writedata  = {30'd0, MASK_INIT};
        end
      end
      RD_CAP: begin
        chipselect = 1'b1;
        read       = 1'b1;
        address    = A_EDGE;
      end
      WR_CLR: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = A_EDGE;
        writedata  = {30'd0, r_edges};
      end
      RD_DAT: begin
        chipselect = 1'b1;
        read       = 1'b1;
        address    = A_DATA;
      end
      default: begin
      end
    endcase
  end

  assign event_valid = (r_state == PUSH);
  assign event_edges = r_edges;
  assign event_level = r_level;
  assign timeout_err = r_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= INIT_MASK;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_next;
      r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= 8'd0;
    end else if (w_cnt_clr) begin
      r_cnt <= 8'd0;
    end else if (w_cnt_inc) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edges <= 2'd0;
      r_level <= 2'd0;
    end else begin
      if (w_cap_ld) begin
        r_edges <= readdata[1:0];
      end
      if (w_lvl_ld) begin
        r_level <= readdata[1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if (w_to) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: doc/unsaved_sw_irq_master.md
UNSAVED_SW_IRQ_MASTER -- requirements
Module: unsaved_SW_irq_master

Interface
REQ-001 Parameter MASK_INIT, default 2'b11: value written to the switch PIO irq_mask register (offset 2) after reset.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles waited for readdatavalid before abort; legal range 1-255.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset_n  input  1  asynchronous active-low reset.
REQ-005 Port irq  input  1  level interrupt from the switch PIO.
REQ-006 Port address  output  2  Avalon-MM word offset to the PIO.
REQ-007 Port chipselect  output  1  transfer select.
REQ-008 Port read  output  1  read request, valid only with chipselect.
REQ-009 Port write_n  output  1  active-low write strobe, valid only with chipselect.
REQ-010 Port writedata  output  32  write data.
REQ-011 Port readdata  input  32  read data; only bits [1:0] used.
REQ-012 Port waitrequest  input  1  slave stall; request held while high.
REQ-013 Port readdatavalid  input  1  marks readdata valid, one pulse per accepted read.
REQ-014 Port event_valid  output  1  switch event available.
REQ-015 Port event_ready  input  1  consumer accepts event when high with event_valid.
REQ-016 Port event_edges  output  2  edge_capture bits of the event.
REQ-017 Port event_level  output  2  switch levels read after clear.
REQ-018 Port timeout_err  output  1  sticky flag, set on readdatavalid timeout.

Function
REQ-019 FSM states SHALL be: INIT_MASK, IDLE, RD_CAP, WT_CAP, WR_CLR, RD_DAT, WT_DAT, PUSH.
REQ-020 INIT_MASK SHALL drive chipselect=1, write_n=0, address=2, writedata={30'b0,MASK_INIT}; holds while waitrequest=1; -> IDLE on first cycle with waitrequest=0.
REQ-021 IDLE SHALL keep chipselect=0, read=0, write_n=1; -> RD_CAP when irq=1.
REQ-022 RD_CAP SHALL drive chipselect=1, read=1, address=3 until waitrequest=0; then -> WT_CAP with timeout counter cleared.
REQ-023 WT_CAP: on readdatavalid latch readdata[1:0] into edge register; if value is 0 (spurious) -> IDLE, else -> WR_CLR.
REQ-024 WR_CLR SHALL write latched edges to address 3 (chipselect=1, write_n=0), held until waitrequest=0; then -> RD_DAT.
REQ-025 RD_DAT/WT_DAT SHALL read address 0 with the same handshake as REQ-022/023; latch readdata[1:0] into level register; -> PUSH.
REQ-026 PUSH SHALL assert event_valid with edge and level registers stable; -> IDLE in the cycle event_valid and event_ready are both 1.
REQ-027 The master SHALL never assert read and ~write_n together, and never issue a new request before the prior read's readdatavalid.
REQ-028 readdatavalid arriving outside WT_CAP/WT_DAT SHALL be ignored.
REQ-029 Timeout counter (8 bit) SHALL increment each cycle in WT_CAP/WT_DAT without readdatavalid; reaching TIMEOUT sets timeout_err=1 and -> IDLE, no event.
REQ-030 irq still high on return to IDLE SHALL start a new service sequence on the next cycle (one idle cycle minimum between sequences).
REQ-031 Edges arriving between the capture read and the clear write are lost; accepted behaviour, no recovery required.
REQ-032 Worst-case latency irq->event_valid with zero wait states and read latency 1: 7 cycles.

Reset
REQ-033 On reset_n=0 the FSM SHALL enter INIT_MASK asynchronously; chipselect=0, read=0, write_n=1, address=0, writedata=0, event_valid=0, event_edges=0, event_level=0, timeout_err=0, counter=0.
REQ-034 Reset mid-transfer SHALL abandon the transfer and any pending event; after release, INIT_MASK re-runs before any read.
REQ-035 timeout_err SHALL clear only by reset.

Verification
REQ-036 Reset release, waitrequest=0 -> one write addr 2 data 0x3, then idle bus.
REQ-037 irq=1, capture returns 0x1, data returns 0x3, event_ready=1 -> write addr 3 data 0x1; event_valid one cycle, edges=01, level=11.
REQ-038 waitrequest high 4 cycles on each request -> requests held stable, event identical to REQ-037, latency +12.
REQ-039 Capture read returns 0x0 -> no clear write, no event, return to IDLE.
REQ-040 readdatavalid withheld, TIMEOUT=8 -> timeout_err=1 after 8 cycles, IDLE; irq still high restarts sequence.
REQ-041 event_ready low 10 cycles in PUSH -> event_valid held with stable data, no bus activity; reset asserted in PUSH -> event_valid=0 immediately.
